// File: rtl/sync_down_counter.sv
// ============================================================================
// Module   : sync_down_counter
// Purpose  : Synchronous modulo-MODULUS down counter with parallel load,
//            count enable, zero flag and a registered borrow pulse.
//            Define DOWN_SAT_EN for a saturating one-shot countdown.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_down_counter #(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count;
  logic             wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      // Out-of-range load values clamp so count never leaves 0..MODULUS-1.
      count <= (load_val > TOP_VAL) ? TOP_VAL : load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      if (count != '0) begin
        count <= count - WIDTH'(1);
        wrap  <= 1'b0;
      end else begin
`ifdef DOWN_SAT_EN
        count <= '0;
        wrap  <= 1'b0;
`else
        count <= TOP_VAL;
        wrap  <= 1'b1;
`endif
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign s      = count;
  assign zero   = (count == '0);
  assign borrow = wrap;

endmodule

`default_nettype wire

// File: tb/tb_sync_down_counter.sv
// Scoreboarded random test of sync_down_counter at MODULUS=32 and MODULUS=10.
`default_nettype none

module tb_sync_down_counter;

  localparam int W    = 5;
  localparam int MODA = 32;
  localparam int MODB = 10;

  logic         clk = 1'b1;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] s_a, s_b;
  logic         zero_a, zero_b, borrow_a, borrow_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sa;
    int ba;
    int sb;
    int bb;
  } exp_t;

  exp_t q[$];

  // Reference state of the two counters.
  int cnt_a = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(W), .MODULUS(MODA)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .s(s_a), .zero(zero_a), .borrow(borrow_a)
  );

  sync_down_counter #(.WIDTH(W), .MODULUS(MODB)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .s(s_b), .zero(zero_b), .borrow(borrow_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural step: returns next count and borrow for one rising edge.
  function automatic void model_step(input int cnt, input int modulus,
                                     input bit ld, input int lv, input bit e,
                                     output int nxt, output int brw);
    brw = 0;
    if (ld)
      nxt = (lv < modulus) ? lv : modulus - 1;
    else if (e) begin
`ifdef DOWN_SAT_EN
      nxt = (cnt > 0) ? cnt - 1 : 0;
`else
      nxt = (cnt + modulus - 1) % modulus;
      brw = (cnt == 0) ? 1 : 0;
`endif
    end else
      nxt = cnt;
  endfunction

  // Apply inputs, let one edge happen, then record what the DUTs must show.
  task automatic cycle(input bit ld, input int lv, input bit e);
    exp_t x;
    load     = ld;
    load_val = W'(lv);
    en       = e;
    @(posedge clk);
    model_step(cnt_a, MODA, ld, lv, e, x.sa, x.ba);
    model_step(cnt_b, MODB, ld, lv, e, x.sb, x.bb);
    cnt_a = x.sa;
    cnt_b = x.sb;
    q.push_back(x);
    #1;
  endtask

  // Monitor: compare registered outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("s_a",      int'(s_a),      e.sa);
      check("zero_a",   int'(zero_a),   (e.sa == 0) ? 1 : 0);
      check("borrow_a", int'(borrow_a), e.ba);
      check("s_b",      int'(s_b),      e.sb);
      check("zero_b",   int'(zero_b),   (e.sb == 0) ? 1 : 0);
      check("borrow_b", int'(borrow_b), e.bb);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held from t=0; check state before any edge.
    #2;
    check("rst_s_a",      int'(s_a),      0);
    check("rst_zero_a",   int'(zero_a),   1);
    check("rst_borrow_a", int'(borrow_a), 0);
    check("rst_s_b",      int'(s_b),      0);
    #3 reset = 1'b1;

    // Continuous count through two wraps.
    for (int i = 0; i < 34; i++) cycle(1'b0, 0, 1'b1);

    // Load beats enable; clamp on the MODULUS=10 instance.
    cycle(1'b1, 10, 1'b0);
    cycle(1'b1, 7, 1'b1);
    cycle(1'b1, 12, 1'b0);

    // Hold.
    cycle(1'b1, 13, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b0);

    // Asynchronous reset between edges.
    cycle(1'b1, 18, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_s_a",      int'(s_a),      0);
    check("mid_rst_zero_a",   int'(zero_a),   1);
    check("mid_rst_borrow_a", int'(borrow_a), 0);
    check("mid_rst_s_b",      int'(s_b),      0);
    cnt_a = 0;
    cnt_b = 0;
    #1 reset = 1'b1;
    cycle(1'b0, 0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 7) == 0), int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous modulo-N down counter; the counting-direction counterpart of the ripple up counter (contador).
- Used for countdown timers and for descending address or sequence generation.
- Provides parallel load, count enable, a zero flag and a registered borrow pulse.
- Borrow output cascades into the enable of a following stage.

Parameters:
- WIDTH, 5, counter width in bits.
- MODULUS, 32, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; decrement on a clk edge when high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value captured when load=1.
- s  output  WIDTH  current count, registered.
- zero  output  1  high whenever s==0; combinational from s.
- borrow  output  1  one-cycle registered pulse on the wrap from 0 to MODULUS-1.

Behaviour:
- Reset: reset=0 forces s=0 and borrow=0 immediately, independent of clk. zero=1 during reset. Deassertion is sampled on clk; the first rising edge with reset=1 may update state.
- Priority per rising edge, highest first: load, en, hold.
- load=1:
  - s <= load_val if load_val < MODULUS, else s <= MODULUS-1 (clamp).
  - borrow <= 0.
  - en is ignored that cycle.
- load=0, en=1, s>0: s <= s-1; borrow <= 0.
- load=0, en=1, s==0: s <= MODULUS-1; borrow <= 1.
- load=0, en=0: s holds; borrow <= 0.
- Latency: a change on s is visible one clk after the controlling edge. borrow is high for exactly the one cycle following the wrap edge. zero has no added latency relative to s.
- Continuous en=1 traces MODULUS-1 ... 1, 0, MODULUS-1 ... with period MODULUS. borrow asserts once per period.
- Internal state: COUNT and WRAP, with the next state derived from s. No other hidden state.
- Arithmetic is unsigned WIDTH-bit. Never produce s >= MODULUS, including when MODULUS < 2**WIDTH.
- Reset asserted mid-count: s=0 and borrow=0 at once. Counting resumes from 0, so the first enabled edge wraps and pulses borrow.
- Cascading: a stage driven by another stage's borrow decrements once per upstream period.

Optional Feature:
- Macro: DOWN_SAT_EN.
- Defined: saturating mode.
  - en=1 with s==0 keeps s=0 and never asserts borrow.
  - borrow is instead tied 0.
  - zero indicates the terminal state (one-shot countdown).
  - Load behaviour is unchanged.
- Undefined: wrap behaviour as specified above.

Test Plan:
- Reset: reset=0 at t=0, released after 5 time units, en=0 -> s=00000, zero=1, borrow=0.
- Wrap run: after reset, en=1 for 34 edges, MODULUS=32 -> s reads 31,30,...,1,0,31,30. borrow is high only in the cycles after s goes 0->31 (twice). zero is high only when s=0.
- Load priority: s=10, load=1, en=1, load_val=7 -> next s=7 (not 6 or 9). load_val=12, MODULUS=10 -> s=9 (clamp).
- Hold: en=0 for 5 edges at s=13 -> s stays 13, borrow=0 throughout.
- Reset mid-count: reset pulled low at s=18 between edges -> s=0 immediately with no clk edge. Next enabled edge -> s=31, borrow=1.
- DOWN_SAT_EN build: load 2, en=1 for 5 edges -> s=1,0,0,0,0. borrow never 1. zero=1 from the second edge onward.
